fpu_add_arbiter: RTL
====================

# fpu_add_arbiter

Shares one FP32 adder datapath among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one requester at a time. A small state machine holds the operands stable on the adder for LAT cycles, then captures the sum and returns it with the requester's index. The block sits between the issue logic and the single `adder`/`FPU` instance, so the adder is instantiated once and never duplicated.

## Interface
- NREQ, 4, number of requesters (2..8)
- LAT, 2, cycles the operands are held on the adder before the result is sampled (1..15)
- IDW, $clog2(NREQ), width of rsp_id
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  NREQ  per-requester operand-pair valid
- req_a  in  32*NREQ  operand A; requester i occupies [32*i+31:32*i]
- req_b  in  32*NREQ  operand B, same packing
- req_ready  out  NREQ  one-hot grant/accept, combinational
- add_a  out  32  registered operand A to the adder
- add_b  out  32  registered operand B to the adder
- add_busy  out  1  high while the adder is owned (BUSY state)
- add_res  in  32  adder result (combinational adder output)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer accept
- rsp_data  out  32  captured sum
- rsp_id  out  IDW  index of the requester that owns rsp_data

## Operation
- States: IDLE, BUSY, RESP. Encoding is free; state is registered.
- IDLE:
  - The arbiter selects g = first i with req_valid[i], searching ptr, ptr+1, … modulo NREQ.
  - req_ready[g] = 1. All other req_ready bits are 0. If no request is valid, req_ready = 0.
  - On handshake (req_valid[g] & req_ready[g]), the block latches req_a/req_b slice g into add_a/add_b and g into rsp_id, loads cnt = LAT, and moves to BUSY.
- BUSY:
  - req_ready = 0 and add_busy = 1. add_a/add_b are held.
  - cnt decrements each cycle. On the cycle cnt == 1, add_res is latched into rsp_data, rsp_valid is set to 1, and the state moves to RESP.
- RESP:
  - req_ready = 0. rsp_valid, rsp_data and rsp_id are held stable until rsp_ready = 1.
  - On that edge, rsp_valid goes to 0, ptr becomes (rsp_id + 1) mod NREQ, and the state moves to IDLE.
- The pointer wraps: a grant to NREQ-1 sets ptr = 0.
- The arbiter never inspects operand contents. Special cases (NaN, zero, infinity) are handled by the adder.
- Requester contract: req_valid and the operands must be held until accepted. Dropping req_valid before acceptance is legal; that requester simply loses arbitration.

## Timing
- Reset values (asserted asynchronously, not waiting for clk):
  - state = IDLE, ptr = 0, cnt = 0
  - add_a = add_b = 0
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0
  - add_busy = 0, req_ready = 0 while rst is high
- Request accepted at edge T:
  - BUSY during cycles T+1 … T+LAT
  - rsp_valid = 1 from edge T+LAT onward
- Minimum issue-to-issue spacing is LAT+2 cycles, with rsp_ready tied high. The IDLE bubble after RESP is mandatory.
- rsp_ready held low: the block stays in RESP indefinitely, with no grants and no change to rsp_*.
- Simultaneous request and response: an rsp_ready handshake and a new req_valid in the same cycle produce no grant that cycle. The grant is issued in the following IDLE cycle.
- Reset mid-operation: an in-flight operation and any pending response are discarded. Requesters must re-present after reset.
- rsp_ready asserted outside RESP is ignored.

## Configuration
- FPU_ARB_FIXED_PRIO_EN
  - Defined: fixed priority. The lowest-index valid requester always wins, and ptr is neither used nor updated.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Single op, NREQ=4, LAT=2:
  - Stimulus: req_valid = 0001, a = 0x3F800000 (1.0), b = 0x40000000 (2.0).
  - Required: req_ready = 0001 in the same cycle; rsp_valid exactly 2 edges after acceptance; rsp_data = 0x40400000 (3.0); rsp_id = 0.
- Round-robin fairness:
  - Stimulus: all four req_valid held high, rsp_ready = 1, 8 operations.
  - Required: grant order 0,1,2,3,0,1,2,3; issue spacing exactly LAT+2 = 4 cycles.
- Back-pressure:
  - Stimulus: rsp_ready = 0 for 10 cycles after rsp_valid rises, with req_valid = 1111.
  - Required: rsp_data, rsp_id and add_a stable; req_ready = 0 throughout; the next grant occurs one cycle after rsp_ready rises.
- Pointer wrap:
  - Stimulus: only requester 3 valid; after its response, requesters 0 and 3 both valid.
  - Required: grant 0 (ptr wrapped to 0); rsp_id = 0.
- Reset mid-BUSY:
  - Stimulus: assert rst one cycle after acceptance.
  - Required: rsp_valid, rsp_data and add_a go to 0 immediately; the state returns to IDLE; no response is ever produced for the discarded operation.
- Fixed priority (FPU_ARB_FIXED_PRIO_EN defined):
  - Stimulus: req_valid = 1010 held high.
  - Required: every grant goes to requester 1; requester 3 is never granted while 1 remains valid.

Source files
------------

// File: rtl/fpu_add_arbiter_if.sv
// fpu_add_arbiter_if
// Groups the request, adder and response signals of the shared FP32 adder arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// surrounding logic: the requesters, the adder and the result consumer.
interface fpu_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;

  logic [31:0]          add_a;
  logic [31:0]          add_b;
  logic                 add_busy;
  logic [31:0]          add_res;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic [IDW-1:0]       rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, add_res, rsp_ready,
    output req_ready, add_a, add_b, add_busy, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, add_res, rsp_ready,
    input  req_ready, add_a, add_b, add_busy, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter
// Shares a single external FP32 adder among NREQ requesters. A round-robin arbiter
// picks one requester. Its operands are held on the adder for LAT cycles. The sum is
// then captured and returned together with the requester index.
//
// Build option: define FPU_ARB_FIXED_PRIO_EN to switch to fixed priority. With it
// defined, the lowest-index valid requester always wins and the round-robin
// pointer stays at zero.
module fpu_add_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic               clk,
  input logic               rst,
  fpu_add_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     addA_q, addA_d;
  logic [31:0]     addB_q, addB_d;
  logic [31:0]     rspData_q, rspData_d;
  logic [IDW-1:0]  rspId_q, rspId_d;
  logic            rspValid_q, rspValid_d;

  logic [31:0]     reqA [NREQ];
  logic [31:0]     reqB [NREQ];
  logic [IDW-1:0]  searchBase;
  logic [IDW-1:0]  grantIdx;
  logic            grantValid;
  logic [IDW-1:0]  candIdx;
  int              cand;
  logic [NREQ-1:0] readyVec;

  // Split the packed operand buses into one 32-bit word per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign reqA[i] = bus.req_a[32*i +: 32];
    assign reqB[i] = bus.req_b[32*i +: 32];
  end

`ifdef FPU_ARB_FIXED_PRIO_EN
  assign searchBase = '0;
`else
  assign searchBase = ptr_q;
`endif

  // Search for the first valid requester, starting at searchBase and wrapping modulo NREQ.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    candIdx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand    = (int'(searchBase) + k) % NREQ;
      candIdx = IDW'(cand);
      if (!grantValid && bus.req_valid[candIdx]) begin
        grantValid = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  // Drive a one-hot accept, only in IDLE and never while reset is asserted.
  always_comb begin
    readyVec = '0;
    if (state_q == IDLE && !rst && grantValid) begin
      readyVec[grantIdx] = 1'b1;
    end
  end

  // Compute the next state and the datapath updates for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    addA_d     = addA_q;
    addB_d     = addB_q;
    rspData_d  = rspData_q;
    rspId_d    = rspId_q;
    rspValid_d = rspValid_q;
    case (state_q)
      IDLE: begin
        if (grantValid) begin
          addA_d  = reqA[grantIdx];
          addB_d  = reqB[grantIdx];
          rspId_d = grantIdx;
          cnt_d   = 4'(LAT);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          cnt_d      = 4'd0;
          rspData_d  = bus.add_res;
          rspValid_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = IDLE;
`ifndef FPU_ARB_FIXED_PRIO_EN
          if (rspId_q == IDW'(NREQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = rspId_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register the state and datapath. Reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      addA_q     <= '0;
      addB_q     <= '0;
      rspData_q  <= '0;
      rspId_q    <= '0;
      rspValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      addA_q     <= addA_d;
      addB_q     <= addB_d;
      rspData_q  <= rspData_d;
      rspId_q    <= rspId_d;
      rspValid_q <= rspValid_d;
    end
  end

  assign bus.req_ready = readyVec;
  assign bus.add_a     = addA_q;
  assign bus.add_b     = addB_q;
  assign bus.add_busy  = (state_q == BUSY);
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_data  = rspData_q;
  assign bus.rsp_id    = rspId_q;

endmodule
